// File: rtl/kbd_matrix_scan.sv
// 4x4 active-low keypad scanner with per-key debounce for press and release.
// Optional auto-repeat of the held key is built when KBD_REPEAT_EN is defined.
module kbd_matrix_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 20,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0] DBC_N = 8'(DEBOUNCE_N);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    if (SCAN_DIV < 4 || DEBOUNCE_N < 2 || DEBOUNCE_N > 255 ||
        REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
        $error("kbd_matrix_scan: parameter out of range");
    end

    logic [3:0]       sync1_q, col_s_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [1:0]       state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [7:0]       dbc_q, dbc_d, dbc_inc;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             down_q, down_d;
    logic             col_single, col_clear;
    logic [1:0]       col_idx;

    assign tick    = (div_q == DIV_LAST);
    assign dbc_inc = (dbc_q == 8'hFF) ? dbc_q : dbc_q + 8'd1;

    // Ghosted samples (two or more low columns) are neither single nor clear.
    always_comb begin
        col_single = 1'b1;
        col_idx    = 2'd0;
        col_clear  = (col_s_q == 4'b1111);
        case (col_s_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_single = 1'b0;
        endcase
    end

`ifdef KBD_REPEAT_EN
    localparam logic [15:0] REP_DLY_C = 16'(REPEAT_DLY);
    localparam logic [15:0] REP_PER_C = 16'(REPEAT_PER);
    logic [15:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dbc_d   = dbc_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
`ifdef KBD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (col_single) begin
                        col_d   = col_idx;
                        dbc_d   = 8'd1;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_single && col_idx == col_q) begin
                        dbc_d = dbc_inc;
                        if (dbc_inc >= DBC_N) begin
                            code_d  = {row_q, col_q};
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            dbc_d   = 8'd0;
                            state_d = ST_HELD;
`ifdef KBD_REPEAT_EN
                            rep_d   = REP_DLY_C;
`endif
                        end
                    end else begin
                        dbc_d   = 8'd0;
                        row_d   = row_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    dbc_d = col_clear ? dbc_inc : 8'd0;
                    if (col_clear && dbc_inc >= DBC_N) begin
                        down_d  = 1'b0;
                        dbc_d   = 8'd0;
                        row_d   = row_q + 2'd1;
                        state_d = ST_SCAN;
                    end
`ifdef KBD_REPEAT_EN
                    // Repeat timing runs from the press strobe, independent of bounces.
                    else if (rep_q <= 16'd1) begin
                        valid_d = 1'b1;
                        rep_d   = REP_PER_C;
                    end else begin
                        rep_d = rep_q - 16'd1;
                    end
`endif
                end
                default: begin
                    dbc_d   = 8'd0;
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            col_s_q <= 4'b1111;
            div_q   <= '0;
            state_q <= ST_SCAN;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            dbc_q   <= 8'd0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            sync1_q <= col_in;
            col_s_q <= sync1_q;
            div_q   <= tick ? '0 : div_q + DIV_W'(1);
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dbc_q   <= dbc_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
        end
    end

`ifdef KBD_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= 16'd0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign row_out   = ~(4'b0001 << row_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Scoreboard bench for kbd_matrix_scan with a behavioural 4x4 keypad matrix.
module tb_kbd_matrix_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys = 16'h0;
    logic [3:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    kbd_matrix_scan #(
        .SCAN_DIV(4), .DEBOUNCE_N(3), .REPEAT_DLY(5), .REPEAT_PER(2)
    ) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cyc=%0d)", name, act, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected key.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(key_code), 32'hFFFF);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("strobe_code", 32'(key_code), 32'(e));
                check("strobe_down", 32'(key_down), 32'd1);
            end
        end
    end

    task automatic clk1();
        @(negedge clk);
        cyc++;
    endtask

    task automatic to_tick();
        do clk1(); while (cyc % 4 != 0);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) clk1();
    endtask

    initial begin
        logic [3:0] exp_row;
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row_out), 32'hE);
        rst = 1'b0;
        cyc = 0;
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_down", 32'(key_down), 32'h0);

        // Idle scan: rows step every 4 cycles and wrap.
        for (int i = 0; i < 5; i++) begin
            exp_row = ~(4'b0001 << (i % 4));
            check("idle_row", 32'(row_out), 32'(exp_row));
            if (i < 4) repeat (4) clk1();
        end

        // Key 9 (row 2, col 1): detect at 28, accept at 36.
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_to(35);
        check("press_down_early", 32'(key_down), 32'd0);
        clk1();
        check("press_down", 32'(key_down), 32'd1);
        check("press_code", 32'(key_code), 32'h9);

        // Release glitch of two clear ticks must not release.
        keys = 16'h0;
        to_tick(); to_tick();
        keys[9] = 1'b1;
        to_tick();
        check("glitch_down", 32'(key_down), 32'd1);

        // Second key while held is ignored.
        keys[2] = 1'b1;
        repeat (4) to_tick();
        check("second_code", 32'(key_code), 32'h9);
        check("second_down", 32'(key_down), 32'd1);

        // Real release: three clear ticks at 68, 72, 76.
        keys = 16'h0;
        to_tick(); to_tick();
        check("release_down_early", 32'(key_down), 32'd1);
        to_tick();
        check("release_down", 32'(key_down), 32'd0);
        check("release_row", 32'(row_out), 32'h7);

        // Bounce: key 9 seen for only two ticks on row 2.
        keys[9] = 1'b1;
        repeat (5) to_tick();
        keys = 16'h0;
        to_tick();
        check("bounce_row", 32'(row_out), 32'h7);
        check("bounce_down", 32'(key_down), 32'd0);

        // Ghosting on row 0: no acceptance, scanning continues.
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        repeat (8) to_tick();
        check("ghost_row", 32'(row_out), 32'h7);
        check("ghost_down", 32'(key_down), 32'd0);
        keys = 16'h0;

        // Hold key 9 again, then reset while held.
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_to(164);
        check("held_down", 32'(key_down), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_row", 32'(row_out), 32'hE);
        check("async_rst_down", 32'(key_down), 32'd0);
        check("async_rst_code", 32'(key_code), 32'h0);
        @(negedge clk);
        check("rst_valid_low", 32'(key_valid), 32'd0);
        rst = 1'b0;
        cyc = 0;
        exp_q.push_back(4'h9);
        wait_to(19);
        check("repress_down_early", 32'(key_down), 32'd0);
        clk1();
        check("repress_down", 32'(key_down), 32'd1);
        check("repress_code", 32'(key_code), 32'h9);
        keys = 16'h0;
        wait_to(32);
        check("repress_release", 32'(key_down), 32'd0);
        check("repress_row", 32'(row_out), 32'h7);

        // Key F: strobe at tick edge 44, repeats at 64, 72, 80, 88 if enabled.
        keys[15] = 1'b1;
        exp_q.push_back(4'hF);
`ifdef KBD_REPEAT_EN
        repeat (4) exp_q.push_back(4'hF);
`endif
        while (cyc < 100) begin
            clk1();
            if (cyc == 64 || cyc == 72 || cyc == 80 || cyc == 88) begin
`ifdef KBD_REPEAT_EN
                check("repeat_strobe", 32'(key_valid), 32'd1);
`else
                check("no_repeat", 32'(key_valid), 32'd0);
`endif
            end
            if (cyc == 68) check("repeat_gap", 32'(key_valid), 32'd0);
            if (cyc == 80) keys = 16'h0;
            if (cyc == 91) check("keyf_down_early", 32'(key_down), 32'd1);
            if (cyc == 92) check("keyf_release", 32'(key_down), 32'd0);
        end
        check("keyf_code_held", 32'(key_code), 32'hF);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
